// File: rtl/mem_bist_sequencer_if.sv
// Shared BIST test port between the sequencer and the per-memory test muxes.
// The sequencer drives address, data and strobes; the selected memory returns read data.
interface mem_bist_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [1:0]        memSel_o;
    logic [ADDR_W-1:0] memAddr_o;
    logic [DATA_W-1:0] memWrData_o;
    logic              memWrEn_o;
    logic              memRdEn_o;
    logic [DATA_W-1:0] memRdData_i;

    modport master (
        output memSel_o, memAddr_o, memWrData_o, memWrEn_o, memRdEn_o,
        input  memRdData_i
    );

    modport slave (
        input  memSel_o, memAddr_o, memWrData_o, memWrEn_o, memRdEn_o,
        output memRdData_i
    );
endinterface

// File: rtl/mem_bist_sequencer.sv
// Write/read-compare BIST sequencer: walks up to four memories one at a time through
// a shared test port and reports pass/fail, fail mask, first fail address and error count.
module mem_bist_sequencer #(
    parameter int                ADDR_W        = 8,
    parameter int                DATA_W        = 8,
    parameter int                MEM1_MAX_ADDR = 32,
    parameter int                MEM2_MAX_ADDR = 32,
    parameter int                MEM3_MAX_ADDR = 32,
    parameter int                MEM4_MAX_ADDR = 32,
    parameter logic [DATA_W-1:0] SEED          = 8'hAA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [7:0]            bistConfig_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [3:0]            failMask_o,
    output logic [ADDR_W-1:0]     failAddr_o,
    output logic [7:0]            errCount_o,
    mem_bist_sequencer_if.master  mem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [DATA_W-1:0] data_t;

    // One extra counter bit so a full 2^ADDR_W sweep can reach its last index without wrapping.
    localparam cnt_t LAST0 = cnt_t'(MEM1_MAX_ADDR - 1);
    localparam cnt_t LAST1 = cnt_t'(MEM2_MAX_ADDR - 1);
    localparam cnt_t LAST2 = cnt_t'(MEM3_MAX_ADDR - 1);
    localparam cnt_t LAST3 = cnt_t'(MEM4_MAX_ADDR - 1);

    function automatic data_t next_pat(input data_t p, input logic [1:0] kind);
        case (kind)
            2'b00:   next_pat = ~p;
            2'b01:   next_pat = p + data_t'(1);
            2'b10:   next_pat = p - data_t'(1);
            default: next_pat = '1;
        endcase
    endfunction

    function automatic data_t seed_for(input logic odd_pass);
        seed_for = odd_pass ? ~SEED : SEED;
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        pat_type_q, pat_type_d;
    logic [1:0]        pass_max_q, pass_max_d;
    logic [3:0]        remaining_q, remaining_d;
    logic [1:0]        mem_sel_q, mem_sel_d;
    cnt_t              addr_q, addr_d;
    logic [1:0]        pass_q, pass_d;
    data_t             data_q, data_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    data_t             exp_q, exp_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_ok_q, pass_ok_d;
    logic [3:0]        fail_mask_q, fail_mask_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [7:0]        err_count_q, err_count_d;

    logic [1:0] pick_idx;
    cnt_t       last_addr;

    always_comb begin
        pick_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (remaining_q[i]) pick_idx = 2'(i);
        end
        case (mem_sel_q)
            2'd0:    last_addr = LAST0;
            2'd1:    last_addr = LAST1;
            2'd2:    last_addr = LAST2;
            default: last_addr = LAST3;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from a default so no path through the case leaves it unassigned (no latches).
        state_d     = state_q;
        pat_type_d  = pat_type_q;
        pass_max_d  = pass_max_q;
        remaining_d = remaining_q;
        mem_sel_d   = mem_sel_q;
        addr_d      = addr_q;
        pass_d      = pass_q;
        data_d      = data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        exp_d       = exp_q;
        cmp_valid_d = 1'b0;
        cmp_addr_d  = cmp_addr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_ok_d   = pass_ok_q;
        fail_mask_d = fail_mask_q;
        fail_addr_d = fail_addr_q;
        err_count_d = err_count_q;

        // Read data for the strobe issued last cycle arrives now.
        if (cmp_valid_q && (mem.memRdData_i != exp_q)) begin
            fail_mask_d[mem_sel_q] = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            if (err_count_q == 8'd0)  fail_addr_d = cmp_addr_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    pat_type_d  = bistConfig_i[5:4];
                    pass_max_d  = bistConfig_i[7:6];
                    remaining_d = bistConfig_i[3:0];
                    fail_mask_d = '0;
                    fail_addr_d = '0;
                    err_count_d = '0;
                    done_d      = 1'b0;
                    pass_ok_d   = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (|remaining_q) begin
                    mem_sel_d             = pick_idx;
                    remaining_d[pick_idx] = 1'b0;
                    addr_d                = '0;
                    pass_d                = '0;
                    data_d                = SEED;
                    wr_en_d               = 1'b1;
                    state_d               = S_WRITE;
                end else begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_ok_d = (fail_mask_q == 4'b0000);
                    state_d   = S_DONE;
                end
            end
            S_WRITE: begin
                if (addr_q == last_addr) begin
                    addr_d  = '0;
                    data_d  = seed_for(pass_q[0]);
                    rd_en_d = 1'b1;
                    state_d = S_READ;
                end else begin
                    addr_d  = addr_q + cnt_t'(1);
                    data_d  = next_pat(data_q, pat_type_q);
                    wr_en_d = 1'b1;
                end
            end
            S_READ: begin
                exp_d       = data_q;
                cmp_addr_d  = addr_q[ADDR_W-1:0];
                cmp_valid_d = 1'b1;
                if (addr_q == last_addr) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d  = addr_q + cnt_t'(1);
                    data_d  = next_pat(data_q, pat_type_q);
                    rd_en_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (pass_q != pass_max_q) begin
                    pass_d  = pass_q + 2'd1;
                    addr_d  = '0;
                    data_d  = seed_for(~pass_q[0]);
                    wr_en_d = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_SELECT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pat_type_q  <= '0;
            pass_max_q  <= '0;
            remaining_q <= '0;
            mem_sel_q   <= '0;
            addr_q      <= '0;
            pass_q      <= '0;
            data_q      <= SEED;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            exp_q       <= '0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_ok_q   <= 1'b0;
            fail_mask_q <= '0;
            fail_addr_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pat_type_q  <= pat_type_d;
            pass_max_q  <= pass_max_d;
            remaining_q <= remaining_d;
            mem_sel_q   <= mem_sel_d;
            addr_q      <= addr_d;
            pass_q      <= pass_d;
            data_q      <= data_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            exp_q       <= exp_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_ok_q   <= pass_ok_d;
            fail_mask_q <= fail_mask_d;
            fail_addr_q <= fail_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_ok_q;
    assign failMask_o      = fail_mask_q;
    assign failAddr_o      = fail_addr_q;
    assign errCount_o      = err_count_q;
    assign mem.memSel_o    = mem_sel_q;
    assign mem.memAddr_o   = addr_q[ADDR_W-1:0];
    assign mem.memWrData_o = data_q;
    assign mem.memWrEn_o   = wr_en_q;
    assign mem.memRdEn_o   = rd_en_q;

endmodule

// File: tb/tb_mem_bist_sequencer.sv
// Scoreboard bench for mem_bist_sequencer: expected strobes and completion reports are queued
// at stimulus time and popped by a monitor whenever the DUT strobes the port or raises done_o.
module tb_mem_bist_sequencer;
    localparam int N0 = 32;
    localparam int N1 = 32;
    localparam int N2 = 256;
    localparam int N3 = 32;

    typedef struct {
        logic       we;
        logic [1:0] sel;
        logic [7:0] addr;
        logic [7:0] data;
    } strobe_t;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] faddr;
        logic [7:0] cnt;
        logic       pass;
        int         lat;
    } result_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] cfg = 8'h00;
    logic       busy_o, done_o, pass_o;
    logic [3:0] fail_mask;
    logic [7:0] fail_addr, err_count;

    mem_bist_sequencer_if #(.ADDR_W(8), .DATA_W(8)) mem_if ();

    mem_bist_sequencer #(
        .ADDR_W(8), .DATA_W(8),
        .MEM1_MAX_ADDR(N0), .MEM2_MAX_ADDR(N1), .MEM3_MAX_ADDR(N2), .MEM4_MAX_ADDR(N3),
        .SEED(8'hAA)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .bistConfig_i(cfg),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .failMask_o(fail_mask), .failAddr_o(fail_addr), .errCount_o(err_count),
        .mem(mem_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int start_cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int fault_mode = 0;
    strobe_t strobe_q[$];
    result_t res_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 1-cycle read latency, with optional injected faults.
    logic [7:0] mem_arr [4][256];
    always @(posedge clk) begin
        if (mem_if.memWrEn_o) mem_arr[mem_if.memSel_o][mem_if.memAddr_o] <= mem_if.memWrData_o;
        if (mem_if.memRdEn_o) begin
            if (fault_mode == 2)
                mem_if.memRdData_i <= 8'h00;
            else if (fault_mode == 1 && mem_if.memSel_o == 2'd0 && mem_if.memAddr_o == 8'd5)
                mem_if.memRdData_i <= mem_arr[mem_if.memSel_o][mem_if.memAddr_o] & 8'hFE;
            else
                mem_if.memRdData_i <= mem_arr[mem_if.memSel_o][mem_if.memAddr_o];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    function automatic int n_of(input int m);
        case (m)
            0:       n_of = N0;
            1:       n_of = N1;
            2:       n_of = N2;
            default: n_of = N3;
        endcase
    endfunction

    function automatic logic [7:0] model_next(input logic [7:0] p, input logic [1:0] kind);
        case (kind)
            2'b00:   model_next = p ^ 8'hFF;
            2'b01:   model_next = 8'(p + 8'd1);
            2'b10:   model_next = 8'(p + 8'hFF);
            default: model_next = 8'hFF;
        endcase
    endfunction

    task automatic push_strobes(input logic [7:0] c);
        int         n;
        int         passes;
        logic [7:0] p;
        passes = int'(c[7:6]) + 1;
        for (int m = 0; m < 4; m++) begin
            if (c[m]) begin
                n = n_of(m);
                for (int ps = 0; ps < passes; ps++) begin
                    for (int ph = 0; ph < 2; ph++) begin
                        p = (ps % 2 == 1) ? 8'h55 : 8'hAA;
                        for (int a = 0; a < n; a++) begin
                            strobe_q.push_back('{we: (ph == 0), sel: 2'(m), addr: 8'(a), data: p});
                            p = model_next(p, c[5:4]);
                        end
                    end
                end
            end
        end
    endtask

    // Monitor: pops one expected strobe per strobe cycle and one report per done_o rise.
    initial begin
        strobe_t s;
        result_t r;
        logic    done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_if.memWrEn_o || mem_if.memRdEn_o) begin
                if (strobe_q.size() == 0) begin
                    note_fail($sformatf("unexpected_strobe we=%0b re=%0b sel=%0d addr=%0h",
                              mem_if.memWrEn_o, mem_if.memRdEn_o, mem_if.memSel_o, mem_if.memAddr_o));
                end else begin
                    s = strobe_q.pop_front();
                    check("strobe{we,re,sel,addr,wdata}",
                          {mem_if.memWrEn_o, mem_if.memRdEn_o, mem_if.memSel_o, mem_if.memAddr_o,
                           mem_if.memWrEn_o ? mem_if.memWrData_o : 8'h00},
                          {s.we, !s.we, s.sel, s.addr, s.we ? s.data : 8'h00});
                end
            end
            if (done_o && !done_prev) begin
                if (res_q.size() == 0) begin
                    note_fail("unexpected_done");
                end else begin
                    r = res_q.pop_front();
                    check("fail_mask", fail_mask, r.mask);
                    check("fail_addr", fail_addr, r.faddr);
                    check("err_count", err_count, r.cnt);
                    check("pass", pass_o, r.pass);
                    check("done_latency", cyc - start_cyc, r.lat);
                end
            end
            done_prev = done_o;
        end
    end

    task automatic pulse_start(input logic [7:0] c);
        @(negedge clk);
        cfg       = c;
        start_i   = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run(input string tag, input logic [7:0] c, input int mode,
                       input result_t r, input bit poke);
        bit seen;
        fault_mode = mode;
        push_strobes(c);
        res_q.push_back(r);
        pulse_start(c);
        check({tag, "_busy_after_start"}, busy_o, 1'b1);
        check({tag, "_done_cleared"}, done_o, 1'b0);
        if (poke) begin
            // Config changes and a second start while busy must be ignored.
            cfg = 8'hFF;
            repeat (3) @(negedge clk);
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) note_fail({tag, "_done_timeout"});
        @(negedge clk);
        check({tag, "_strobes_left"}, strobe_q.size(), 0);
        check({tag, "_busy_at_done"}, busy_o, 1'b0);
        if (res_q.size() != 0) begin
            note_fail({tag, "_report_missing"});
            res_q.delete();
        end
        strobe_q.delete();
    endtask

    initial begin
        bit rd_seen;
        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_outputs", {busy_o, done_o, pass_o, fail_mask, fail_addr, err_count},
              {1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00});
        check("rst_port", {mem_if.memWrEn_o, mem_if.memRdEn_o, mem_if.memSel_o, mem_if.memAddr_o,
                           mem_if.memWrData_o}, {1'b0, 1'b0, 2'd0, 8'h00, 8'hAA});
        @(negedge clk);
        reset = 1'b1;

        // Latency is 1 + sum over enabled memories of 1 + P*(2N+1), counted from the start-sampling edge.
        run("t1_inv", 8'h01, 0, '{mask: 4'h0, faddr: 8'h00, cnt: 8'h00, pass: 1'b1, lat: 67}, 1'b0);
        run("t2_inc2", 8'h5A, 0, '{mask: 4'h0, faddr: 8'h00, cnt: 8'h00, pass: 1'b1, lat: 263}, 1'b1);
        run("t3_stuck", 8'h31, 1, '{mask: 4'h1, faddr: 8'h05, cnt: 8'h01, pass: 1'b0, lat: 67}, 1'b0);
        run("t4_sat", 8'hDF, 2, '{mask: 4'hF, faddr: 8'h00, cnt: 8'hFF, pass: 1'b0, lat: 2837}, 1'b0);
        run("t5_full", 8'h04, 0, '{mask: 4'h0, faddr: 8'h00, cnt: 8'h00, pass: 1'b1, lat: 515}, 1'b0);
        run("t6_none", 8'h00, 0, '{mask: 4'h0, faddr: 8'h00, cnt: 8'h00, pass: 1'b1, lat: 1}, 1'b0);

        // Reset asserted mid-READ after a run that left failure state behind.
        run("t7_pre", 8'h31, 1, '{mask: 4'h1, faddr: 8'h05, cnt: 8'h01, pass: 1'b0, lat: 67}, 1'b0);
        fault_mode = 1;
        push_strobes(8'h01);
        pulse_start(8'h01);
        rd_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mem_if.memRdEn_o) begin
                rd_seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!rd_seen) note_fail("t7_read_timeout");
        repeat (8) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t7_async_outputs", {busy_o, done_o, pass_o, fail_mask, fail_addr, err_count},
              {1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00});
        check("t7_async_port", {mem_if.memWrEn_o, mem_if.memRdEn_o, mem_if.memSel_o, mem_if.memAddr_o,
                                mem_if.memWrData_o}, {1'b0, 1'b0, 2'd0, 8'h00, 8'hAA});
        strobe_q.delete();
        @(negedge clk);
        reset = 1'b1;
        run("t8_after_rst", 8'h01, 0, '{mask: 4'h0, faddr: 8'h00, cnt: 8'h00, pass: 1'b1, lat: 67}, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
